// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// cpu_types_pkg : shared CPU types and constants (fetch state, NOP, PC step)
// Revision 1.0
// ------------------------------------------------------------------
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    BUFFERED = 2'd1,
    HALTED   = 2'd2
  } fetch_state_t;

  // 32'h0 decodes as sll r0,r0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_decode_if.sv
`default_nettype none
// ------------------------------------------------------------------
// fetch_decode_if : IF/ID pipeline register contents seen by decode
// Revision 1.0
// ------------------------------------------------------------------
interface fetch_decode_if;
  logic [31:0] instruction;
  logic [31:0] instr_npc;

  modport fetch  (output instruction, output instr_npc);
  modport decode (input  instruction, input  instr_npc);
endinterface
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ------------------------------------------------------------------
// fetch_buffer : one-entry holding register for a word fetched during a stall
// Revision 1.0
// ------------------------------------------------------------------
module fetch_buffer
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        i_load,
  input  logic        i_drain,
  input  logic        i_clear,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_npc,
  output logic [31:0] o_instr,
  output logic [31:0] o_npc,
  output logic        o_valid
);

  // clear/drain win over load: a squashed or consumed entry is never refilled in the same cycle
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      o_instr <= NOP_INSTR;
      o_npc   <= '0;
      o_valid <= 1'b0;
    end else if (i_clear || i_drain) begin
      o_valid <= 1'b0;
    end else if (i_load) begin
      o_instr <= i_instr;
      o_npc   <= i_npc;
      o_valid <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ------------------------------------------------------------------
// fetch_stage : PC, icache request and IF/ID register; FETCH_STATS_EN adds counters
// Revision 1.0
// ------------------------------------------------------------------
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          en,
  input  logic          redirect,
  input  logic [31:0]   redirect_target,
  input  logic          halt,
  input  logic          ihit,
  input  logic [31:0]   imemload,
  fetch_decode_if.fetch out,
  output logic          imemREN,
  output logic [31:0]   imemaddr,
  output logic          fetch_stall
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]   fetch_count,
  output logic [31:0]   stall_count
`endif
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_plus;
  logic         w_take_redirect;
  logic         w_fetch_load;
  logic         w_buf_load;
  logic         w_buf_drain;
  logic         w_buf_clear;
  logic [31:0]  w_buf_instr;
  logic [31:0]  w_buf_npc;
  logic         w_buf_valid;

  assign w_pc_plus       = r_pc + PC_STEP;
  assign w_take_redirect = en && redirect && (r_state != HALTED);

  assign imemREN     = (r_state == FETCH);
  assign imemaddr    = word_align(r_pc);
  assign fetch_stall = (r_state == FETCH) && !ihit;

  assign w_fetch_load = (r_state == FETCH) && ihit && en && !redirect && !halt;
  assign w_buf_load   = (r_state == FETCH) && ihit && !en && !halt;
  assign w_buf_drain  = (r_state == BUFFERED) && en && !redirect && !halt && w_buf_valid;
  assign w_buf_clear  = halt || w_take_redirect;

  fetch_buffer u_fetch_buffer (
    .CLK     (CLK),
    .nRST    (nRST),
    .i_load  (w_buf_load),
    .i_drain (w_buf_drain),
    .i_clear (w_buf_clear),
    .i_instr (imemload),
    .i_npc   (w_pc_plus),
    .o_instr (w_buf_instr),
    .o_npc   (w_buf_npc),
    .o_valid (w_buf_valid)
  );

  // halt beats redirect; redirect beats any same-cycle hit
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state         <= FETCH;
      r_pc            <= PC_INIT;
      out.instruction <= NOP_INSTR;
      out.instr_npc   <= '0;
    end else if (halt) begin
      r_state <= HALTED;
      if (en) begin
        out.instruction <= NOP_INSTR;
        out.instr_npc   <= '0;
      end
    end else if (w_take_redirect) begin
      r_state         <= FETCH;
      r_pc            <= word_align(redirect_target);
      out.instruction <= NOP_INSTR;
      out.instr_npc   <= '0;
    end else begin
      case (r_state)
        FETCH: begin
          if (ihit) begin
            r_pc <= w_pc_plus;
            if (en) begin
              out.instruction <= imemload;
              out.instr_npc   <= w_pc_plus;
            end else begin
              r_state <= BUFFERED;
            end
          end else if (en) begin
            out.instruction <= NOP_INSTR;
            out.instr_npc   <= '0;
          end
        end
        BUFFERED: begin
          if (en) begin
            out.instruction <= w_buf_instr;
            out.instr_npc   <= w_buf_npc;
            r_state         <= FETCH;
          end
        end
        HALTED: begin
          if (en) begin
            out.instruction <= NOP_INSTR;
            out.instr_npc   <= '0;
          end
        end
        default: r_state <= FETCH;
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if ((w_fetch_load || w_buf_drain) && (fetch_count != 32'hFFFF_FFFF))
        fetch_count <= fetch_count + 32'd1;
      if (fetch_stall && (stall_count != 32'hFFFF_FFFF))
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_fetch_stage : directed vector table plus randomized run against a reference model
// Revision 1.0
// ------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] C_PC_INIT = 32'h0000_0100;
  localparam int          C_NV      = 28;
  localparam int          M_RUN     = 0;
  localparam int          M_HELD    = 1;
  localparam int          M_STOP    = 2;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        en, redirect, halt, ihit;
  logic [31:0] redirect_target, imemload;
  logic        imemREN, fetch_stall;
  logic [31:0] imemaddr;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count, stall_count;
`endif

  fetch_decode_if fdif ();

  fetch_stage #(.PC_INIT(C_PC_INIT)) dut (
    .CLK             (CLK),
    .nRST            (nRST),
    .en              (en),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .halt            (halt),
    .ihit            (ihit),
    .imemload        (imemload),
    .out             (fdif),
    .imemREN         (imemREN),
    .imemaddr        (imemaddr),
    .fetch_stall     (fetch_stall)
`ifdef FETCH_STATS_EN
    ,
    .fetch_count     (fetch_count),
    .stall_count     (stall_count)
`endif
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        en, rd, hlt, hit;
    logic [31:0] tgt;
    logic        ren;
    logic [31:0] addr;
    logic        stall;
    logic [31:0] instr, npc;
    logic        ld;
  } vec_t;

  vec_t tbl [C_NV];

  function automatic vec_t mkv(input int e, input int r, input logic [31:0] t, input int h,
                               input int hi, input int ren, input logic [31:0] a, input int st,
                               input logic [31:0] ins, input logic [31:0] np, input int ld);
    vec_t v;
    v.en = (e != 0); v.rd = (r != 0); v.tgt = t; v.hlt = (h != 0); v.hit = (hi != 0);
    v.ren = (ren != 0); v.addr = a; v.stall = (st != 0); v.instr = ins; v.npc = np; v.ld = (ld != 0);
    return v;
  endfunction

  // reference model state
  int          m_mode;
  logic [31:0] m_pc, m_instr, m_npc, m_bi, m_bn;
  int          m_fc, m_sc;

  function automatic void model_reset();
    m_mode = M_RUN; m_pc = C_PC_INIT; m_instr = 32'h0; m_npc = 32'h0;
    m_bi = 32'h0; m_bn = 32'h0; m_fc = 0; m_sc = 0;
  endfunction

  task automatic check_reset_outputs(input string tag, input logic exp_stall);
    chk({tag, " instruction"}, fdif.instruction, 32'h0);
    chk({tag, " instr_npc"}, fdif.instr_npc, 32'h0);
    chk({tag, " imemREN"}, 32'(imemREN), 32'd1);
    chk({tag, " imemaddr"}, imemaddr, C_PC_INIT);
    chk({tag, " fetch_stall"}, 32'(fetch_stall), 32'(exp_stall));
`ifdef FETCH_STATS_EN
    chk({tag, " fetch_count"}, fetch_count, 32'h0);
    chk({tag, " stall_count"}, stall_count, 32'h0);
`endif
  endtask

  // one cycle, entered and left at a falling edge
  task automatic rand_cycle(input bit force_halt);
    logic e, r, h, hi;
    logic [31:0] t, d;
    logic exp_ren;
    e  = ($urandom_range(0, 3) != 0);
    r  = ($urandom_range(0, 9) == 0);
    hi = ($urandom_range(0, 4) < 3);
    h  = 1'b0;
    t  = $urandom;
    d  = $urandom;
    if (force_halt) begin e = 1'b0; hi = 1'b0; h = 1'b1; end
    en = e; redirect = r; redirect_target = t; halt = h; ihit = hi; imemload = d;
    #1;
    exp_ren = (m_mode == M_RUN);
    chk("rnd imemREN", 32'(imemREN), 32'(exp_ren));
    if (exp_ren) chk("rnd imemaddr", imemaddr, m_pc);
    chk("rnd fetch_stall", 32'(fetch_stall), 32'(exp_ren && !hi));
    if (exp_ren && !hi) m_sc++;
    @(posedge CLK);
    if (h) begin
      m_mode = M_STOP;
    end else if (m_mode != M_STOP && e && r) begin
      m_pc = {t[31:2], 2'b00}; m_instr = 32'h0; m_npc = 32'h0; m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (hi) begin
        if (e) begin m_instr = d; m_npc = m_pc + 32'd4; m_fc++; end
        else begin m_bi = d; m_bn = m_pc + 32'd4; m_mode = M_HELD; end
        m_pc = m_pc + 32'd4;
      end else if (e) begin
        m_instr = 32'h0; m_npc = 32'h0;
      end
    end else if (m_mode == M_HELD) begin
      if (e) begin m_instr = m_bi; m_npc = m_bn; m_fc++; m_mode = M_RUN; end
    end else if (e) begin
      m_instr = 32'h0; m_npc = 32'h0;
    end
    #1;
    chk("rnd instruction", fdif.instruction, m_instr);
    chk("rnd instr_npc", fdif.instr_npc, m_npc);
    @(negedge CLK);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_fc, exp_sc;
    //            en rd tgt            h hit ren addr          st instr          npc          ld
    tbl[0]  = mkv(1, 0, 32'h0,         0, 1, 1, 32'h100,      0, 32'h101,      32'h104,      1);
    tbl[1]  = mkv(1, 0, 32'h0,         0, 1, 1, 32'h104,      0, 32'h105,      32'h108,      1);
    tbl[2]  = mkv(1, 0, 32'h0,         0, 1, 1, 32'h108,      0, 32'h109,      32'h10C,      1);
    tbl[3]  = mkv(1, 1, 32'h200,       0, 1, 1, 32'h10C,      0, 32'h0,        32'h0,        0);
    tbl[4]  = mkv(1, 0, 32'h0,         0, 0, 1, 32'h200,      1, 32'h0,        32'h0,        0);
    tbl[5]  = mkv(1, 0, 32'h0,         0, 0, 1, 32'h200,      1, 32'h0,        32'h0,        0);
    tbl[6]  = mkv(1, 0, 32'h0,         0, 0, 1, 32'h200,      1, 32'h0,        32'h0,        0);
    tbl[7]  = mkv(1, 0, 32'h0,         0, 1, 1, 32'h200,      0, 32'h201,      32'h204,      1);
    tbl[8]  = mkv(1, 1, 32'h3C,        0, 1, 1, 32'h204,      0, 32'h0,        32'h0,        0);
    tbl[9]  = mkv(1, 0, 32'h0,         0, 1, 1, 32'h3C,       0, 32'h3D,       32'h40,       1);
    tbl[10] = mkv(0, 0, 32'h0,         0, 1, 1, 32'h40,       0, 32'h3D,       32'h40,       0);
    tbl[11] = mkv(0, 0, 32'h0,         0, 1, 0, 32'h0,        0, 32'h3D,       32'h40,       0);
    tbl[12] = mkv(1, 0, 32'h0,         0, 0, 0, 32'h0,        0, 32'h41,       32'h44,       1);
    tbl[13] = mkv(1, 0, 32'h0,         0, 1, 1, 32'h44,       0, 32'h45,       32'h48,       1);
    tbl[14] = mkv(0, 0, 32'h0,         0, 1, 1, 32'h48,       0, 32'h45,       32'h48,       0);
    tbl[15] = mkv(1, 1, 32'h800,       0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        0);
    tbl[16] = mkv(1, 0, 32'h0,         0, 1, 1, 32'h800,      0, 32'h801,      32'h804,      1);
    tbl[17] = mkv(1, 1, 32'h10,        0, 1, 1, 32'h804,      0, 32'h0,        32'h0,        0);
    tbl[18] = mkv(1, 1, 32'h3FE,       0, 1, 1, 32'h10,       0, 32'h0,        32'h0,        0);
    tbl[19] = mkv(1, 0, 32'h0,         0, 1, 1, 32'h3FC,      0, 32'h3FD,      32'h400,      1);
    tbl[20] = mkv(0, 1, 32'h900,       0, 0, 1, 32'h400,      1, 32'h3FD,      32'h400,      0);
    tbl[21] = mkv(1, 0, 32'h0,         0, 1, 1, 32'h400,      0, 32'h401,      32'h404,      1);
    tbl[22] = mkv(1, 1, 32'hFFFF_FFFC, 0, 0, 1, 32'h404,      1, 32'h0,        32'h0,        0);
    tbl[23] = mkv(1, 0, 32'h0,         0, 1, 1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFD, 32'h0,      1);
    tbl[24] = mkv(1, 0, 32'h0,         0, 1, 1, 32'h0,        0, 32'h1,        32'h4,        1);
    tbl[25] = mkv(1, 1, 32'h500,       1, 0, 1, 32'h4,        1, 32'h0,        32'h0,        0);
    tbl[26] = mkv(1, 0, 32'h0,         0, 1, 0, 32'h0,        0, 32'h0,        32'h0,        0);
    tbl[27] = mkv(0, 0, 32'h0,         0, 1, 0, 32'h0,        0, 32'h0,        32'h0,        0);

    nRST = 1'b0; en = 1'b0; redirect = 1'b0; halt = 1'b0; ihit = 1'b0;
    redirect_target = 32'h0; imemload = 32'h0;
    #22;
    check_reset_outputs("reset", 1'b1);

    exp_fc = 0; exp_sc = 0;
    @(negedge CLK);
    nRST = 1'b1;
    for (int i = 0; i < C_NV; i++) begin
      en = tbl[i].en; redirect = tbl[i].rd; redirect_target = tbl[i].tgt;
      halt = tbl[i].hlt; ihit = tbl[i].hit; imemload = tbl[i].addr + 32'd1;
      #1;
      chk($sformatf("vec%0d imemREN", i), 32'(imemREN), 32'(tbl[i].ren));
      if (tbl[i].ren) chk($sformatf("vec%0d imemaddr", i), imemaddr, tbl[i].addr);
      chk($sformatf("vec%0d fetch_stall", i), 32'(fetch_stall), 32'(tbl[i].stall));
      @(posedge CLK);
      #1;
      chk($sformatf("vec%0d instruction", i), fdif.instruction, tbl[i].instr);
      chk($sformatf("vec%0d instr_npc", i), fdif.instr_npc, tbl[i].npc);
      if (tbl[i].ld) exp_fc++;
      if (tbl[i].stall) exp_sc++;
      @(negedge CLK);
    end
`ifdef FETCH_STATS_EN
    chk("halted fetch_count", fetch_count, 32'(exp_fc));
    chk("halted stall_count", stall_count, 32'(exp_sc));
    repeat (3) @(negedge CLK);
    chk("frozen fetch_count", fetch_count, 32'(exp_fc));
    chk("frozen stall_count", stall_count, 32'(exp_sc));
`endif

    // asynchronous reset between clock edges, then randomized run
    en = 1'b1; redirect = 1'b0; halt = 1'b0; ihit = 1'b0;
    #2 nRST = 1'b0;
    #1 check_reset_outputs("async reset", 1'b1);
    @(negedge CLK);
    nRST = 1'b1;
    model_reset();
    for (int i = 0; i < 250; i++) rand_cycle(1'b0);

    // reset while a request is outstanding
    en = 1'b1; redirect = 1'b0; halt = 1'b0; ihit = 1'b0;
    #2 nRST = 1'b0;
    #1 check_reset_outputs("mid-miss reset", 1'b1);
    @(negedge CLK);
    nRST = 1'b1;
    model_reset();
    for (int i = 0; i < 200; i++) rand_cycle(1'b0);
    rand_cycle(1'b1);
    for (int i = 0; i < 20; i++) rand_cycle(1'b0);
`ifdef FETCH_STATS_EN
    chk("rnd fetch_count", fetch_count, 32'(m_fc));
    chk("rnd stall_count", stall_count, 32'(m_sc));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
